// File: rtl/xif_alu_coproc.sv
// eXtension-interface ALU coprocessor: ADD/SUB/XOR/AND on custom-0, results held in an in-order queue until commit/kill.
// Latency: result is offered the cycle after its commit event once it reaches the queue head; killed heads drain in one cycle.
// Backpressure: issue ready drops when the queue is full or operands are invalid; a stalled result holds until x_result_ready_i.
module xif_alu_coproc #(
    parameter int DEPTH      = 4,
    parameter int X_ID_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  x_issue_valid_i,
    output logic                  x_issue_ready_o,
    input  logic [31:0]           x_issue_instr_i,
    input  logic [X_ID_WIDTH-1:0] x_issue_id_i,
    input  logic [63:0]           x_issue_rs_i,
    input  logic [1:0]            x_issue_rs_valid_i,
    output logic                  x_issue_accept_o,
    output logic                  x_issue_writeback_o,
    input  logic                  x_commit_valid_i,
    input  logic [X_ID_WIDTH-1:0] x_commit_id_i,
    input  logic                  x_commit_kill_i,
    output logic                  x_result_valid_o,
    input  logic                  x_result_ready_i,
    output logic [X_ID_WIDTH-1:0] x_result_id_o,
    output logic [4:0]            x_result_rd_o,
    output logic [31:0]           x_result_data_o,
    output logic                  x_result_we_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic                  committed;
        logic                  killed;
        logic [X_ID_WIDTH-1:0] id;
        logic [4:0]            rd;
        logic [31:0]           dat;
    } entry_t;

    entry_t            q [DEPTH];
    logic [DEPTH-1:0]  q_vld;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic              dec_ok;
    logic [31:0]       rs1;
    logic [31:0]       rs2;
    logic [31:0]       alu_dat;
    logic              full;
    logic              issue_hs;
    logic              alloc;
    logic              new_hit;
    logic [DEPTH-1:0]  cmt_hit;
    entry_t            head;
    logic              head_vld;
    logic              res_vld;
    logic              pop;
    logic              unused_instr_bits;

    assign opcode = x_issue_instr_i[6:0];
    assign funct3 = x_issue_instr_i[14:12];
    assign funct7 = x_issue_instr_i[31:25];
    assign rs1    = x_issue_rs_i[31:0];
    assign rs2    = x_issue_rs_i[63:32];

    // rs1/rs2 register fields are irrelevant: operands arrive by value
    assign unused_instr_bits = &{1'b0, x_issue_instr_i[24:15]};

    assign dec_ok              = (opcode == 7'b0001011) && (funct7 == 7'd0) && !funct3[2];
    assign x_issue_accept_o    = dec_ok;
    assign x_issue_writeback_o = dec_ok;

    assign full            = (count == (AW+1)'(DEPTH));
    assign x_issue_ready_o = !full && (x_issue_rs_valid_i == 2'b11);
    assign issue_hs        = x_issue_valid_i && x_issue_ready_o;
    assign alloc           = issue_hs && dec_ok;

    always_comb begin
        alu_dat = '0;
        case (funct3[1:0])
            2'b00: alu_dat = rs1 + rs2;
            2'b01: alu_dat = rs1 - rs2;
            2'b10: alu_dat = rs1 ^ rs2;
            2'b11: alu_dat = rs1 & rs2;
            default: alu_dat = '0;
        endcase
    end

    always_comb begin
        cmt_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cmt_hit[i] = x_commit_valid_i && q_vld[i] && (q[i].id == x_commit_id_i);
        end
    end

    // a commit racing its own issue lands on the entry being written this cycle
    assign new_hit = x_commit_valid_i && alloc && (x_issue_id_i == x_commit_id_i);

    assign head     = q[rd_ptr];
    assign head_vld = q_vld[rd_ptr];
    assign res_vld  = head_vld && head.committed && !head.killed;
    assign pop      = head_vld && (head.killed || (head.committed && x_result_ready_i));

    assign x_result_valid_o = res_vld;
    assign x_result_we_o    = res_vld;
    assign x_result_id_o    = res_vld ? head.id  : '0;
    assign x_result_rd_o    = res_vld ? head.rd  : '0;
    assign x_result_data_o  = res_vld ? head.dat : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_vld  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cmt_hit[i]) begin
                    if (x_commit_kill_i) begin
                        q[i].killed <= 1'b1;
                    end else begin
                        q[i].committed <= 1'b1;
                    end
                end
            end
            if (pop) begin
                q_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            // tail slot is never valid here, so it cannot collide with a commit hit or the pop
            if (alloc) begin
                q[wr_ptr].committed <= new_hit && !x_commit_kill_i;
                q[wr_ptr].killed    <= new_hit && x_commit_kill_i;
                q[wr_ptr].id        <= x_issue_id_i;
                q[wr_ptr].rd        <= x_issue_instr_i[11:7];
                q[wr_ptr].dat       <= alu_dat;
                q_vld[wr_ptr]       <= 1'b1;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            case ({alloc, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_xif_alu_coproc.sv
// Bench for xif_alu_coproc: directed scenarios plus randomized traffic against an in-order queue model.
module tb_xif_alu_coproc;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        x_issue_valid_i;
    logic        x_issue_ready_o;
    logic [31:0] x_issue_instr_i;
    logic [3:0]  x_issue_id_i;
    logic [63:0] x_issue_rs_i;
    logic [1:0]  x_issue_rs_valid_i;
    logic        x_issue_accept_o;
    logic        x_issue_writeback_o;
    logic        x_commit_valid_i;
    logic [3:0]  x_commit_id_i;
    logic        x_commit_kill_i;
    logic        x_result_valid_o;
    logic        x_result_ready_i;
    logic [3:0]  x_result_id_o;
    logic [4:0]  x_result_rd_o;
    logic [31:0] x_result_data_o;
    logic        x_result_we_o;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] dat;
        int          st;   // 0 pending, 1 committed, 2 killed
    } mdl_t;

    mdl_t mq[$];

    always #5 clk_i = ~clk_i;

    xif_alu_coproc #(.DEPTH(4), .X_ID_WIDTH(4)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .x_issue_valid_i     (x_issue_valid_i),
        .x_issue_ready_o     (x_issue_ready_o),
        .x_issue_instr_i     (x_issue_instr_i),
        .x_issue_id_i        (x_issue_id_i),
        .x_issue_rs_i        (x_issue_rs_i),
        .x_issue_rs_valid_i  (x_issue_rs_valid_i),
        .x_issue_accept_o    (x_issue_accept_o),
        .x_issue_writeback_o (x_issue_writeback_o),
        .x_commit_valid_i    (x_commit_valid_i),
        .x_commit_id_i       (x_commit_id_i),
        .x_commit_kill_i     (x_commit_kill_i),
        .x_result_valid_o    (x_result_valid_o),
        .x_result_ready_i    (x_result_ready_i),
        .x_result_id_o       (x_result_id_o),
        .x_result_rd_o       (x_result_rd_o),
        .x_result_data_o     (x_result_data_o),
        .x_result_we_o       (x_result_we_o)
    );

    function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd);
        return {7'b0, 5'd2, 5'd1, f3, rd, 7'b0001011};
    endfunction

    function automatic bit id_in_q(input logic [3:0] x);
        foreach (mq[i]) if (mq[i].id == x) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        x_issue_valid_i    = 1'b0;
        x_issue_instr_i    = 32'd0;
        x_issue_id_i       = 4'd0;
        x_issue_rs_i       = 64'd0;
        x_issue_rs_valid_i = 2'b11;
        x_commit_valid_i   = 1'b0;
        x_commit_id_i      = 4'd0;
        x_commit_kill_i    = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        x_result_ready_i = 1'b1;
        rst_ni = 1'b0;
        tick();
        tick();
        #1;
        tests++;
        if ({x_result_valid_o, x_result_we_o} !== 2'b00) begin
            fails++;
            $display("FAIL reset_valid: valid/we=%b required 00", {x_result_valid_o, x_result_we_o});
        end
        tests++;
        if ({x_result_id_o, x_result_rd_o, x_result_data_o} !== 41'd0) begin
            fails++;
            $display("FAIL reset_fields: id=%0d rd=%0d data=%h required 0", x_result_id_o, x_result_rd_o, x_result_data_o);
        end
        tests++;
        if (x_issue_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: ready=%b required 1", x_issue_ready_o);
        end
        x_issue_rs_valid_i = 2'b01;
        #1;
        tests++;
        if (x_issue_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL ready_rs_invalid: ready=%b required 0", x_issue_ready_o);
        end
        x_issue_rs_valid_i = 2'b11;
        rst_ni = 1'b1;
    endtask

    task automatic test_add();
        tick();
        x_issue_valid_i = 1'b1;
        x_issue_instr_i = mk_instr(3'd0, 5'd5);
        x_issue_id_i    = 4'd3;
        x_issue_rs_i    = {32'd9, 32'd7};
        #1;
        tests++;
        if ({x_issue_ready_o, x_issue_accept_o, x_issue_writeback_o} !== 3'b111) begin
            fails++;
            $display("FAIL add_issue: ready/accept/wb=%b required 111", {x_issue_ready_o, x_issue_accept_o, x_issue_writeback_o});
        end
        tick();
        x_issue_valid_i  = 1'b0;
        x_commit_valid_i = 1'b1;
        x_commit_id_i    = 4'd3;
        x_commit_kill_i  = 1'b0;
        #1;
        tests++;
        if (x_result_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL add_early: result valid=%b required 0 in commit cycle", x_result_valid_o);
        end
        tick();
        x_commit_valid_i = 1'b0;
        #1;
        tests++;
        if ({x_result_valid_o, x_result_we_o, x_result_id_o, x_result_rd_o, x_result_data_o} !== {2'b11, 4'd3, 5'd5, 32'd16}) begin
            fails++;
            $display("FAIL add_result: v=%b id=%0d rd=%0d data=%0d required v=1 id=3 rd=5 data=16",
                     x_result_valid_o, x_result_id_o, x_result_rd_o, x_result_data_o);
        end
        tick();
        #1;
        tests++;
        if (x_result_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL add_pop: valid=%b required 0 after pop", x_result_valid_o);
        end
    endtask

    task automatic test_sub_wrap();
        tick();
        x_issue_valid_i  = 1'b1;
        x_issue_instr_i  = mk_instr(3'd1, 5'd7);
        x_issue_id_i     = 4'd0;
        x_issue_rs_i     = {32'd1, 32'd0};
        x_commit_valid_i = 1'b1;
        x_commit_id_i    = 4'd0;
        x_commit_kill_i  = 1'b0;
        tick();
        idle();
        #1;
        tests++;
        if ({x_result_valid_o, x_result_id_o, x_result_rd_o, x_result_data_o} !== {1'b1, 4'd0, 5'd7, 32'hFFFF_FFFF}) begin
            fails++;
            $display("FAIL sub_wrap: v=%b id=%0d rd=%0d data=%h required v=1 id=0 rd=7 data=ffffffff",
                     x_result_valid_o, x_result_id_o, x_result_rd_o, x_result_data_o);
        end
        tick();
        #1;
        tests++;
        if (x_result_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL sub_pop: valid=%b required 0", x_result_valid_o);
        end
    endtask

    task automatic test_kill_order();
        logic [35:0] got[$];
        logic [2:0]  ops [3] = '{3'd0, 3'd2, 3'd3};
        for (int k = 0; k < 12; k++) begin
            tick();
            idle();
            if (k < 3) begin
                x_issue_valid_i = 1'b1;
                x_issue_instr_i = mk_instr(ops[k], 5'(k + 1));
                x_issue_id_i    = 4'(k);
                x_issue_rs_i    = (k == 2) ? {32'h0FF0_FFFF, 32'hF0F0_1234} : {32'd5, 32'd10};
            end else if (k < 6) begin
                x_commit_valid_i = 1'b1;
                x_commit_id_i    = (k == 3) ? 4'd2 : (k == 4) ? 4'd1 : 4'd0;
                x_commit_kill_i  = (k == 4);
            end
            #1;
            if (x_result_valid_o) got.push_back({x_result_id_o, x_result_data_o});
        end
        tests++;
        if (got.size() != 2) begin
            fails++;
            $display("FAIL kill_count: results=%0d required 2", got.size());
        end else begin
            tests++;
            if (got[0] !== {4'd0, 32'd15}) begin
                fails++;
                $display("FAIL kill_first: id/data=%h required 0/0000000f", got[0]);
            end
            tests++;
            if (got[1] !== {4'd2, 32'h00F0_1234}) begin
                fails++;
                $display("FAIL kill_second: id/data=%h required 2/00f01234", got[1]);
            end
        end
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            tick();
            x_issue_valid_i = 1'b1;
            x_issue_instr_i = mk_instr(3'd0, 5'(k));
            x_issue_id_i    = 4'(4 + k);
            x_issue_rs_i    = {32'(k), 32'd100};
            #1;
            tests++;
            if (x_issue_ready_o !== 1'b1) begin
                fails++;
                $display("FAIL full_fill%0d: ready=%b required 1", k, x_issue_ready_o);
            end
        end
        tick();
        x_issue_id_i = 4'd8;
        #1;
        tests++;
        if (x_issue_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL full_fifth: ready=%b required 0", x_issue_ready_o);
        end
        x_issue_valid_i  = 1'b0;
        x_commit_valid_i = 1'b1;
        x_commit_id_i    = 4'd4;
        x_commit_kill_i  = 1'b0;
        tick();
        x_commit_valid_i = 1'b0;
        #1;
        tests++;
        if ({x_result_valid_o, x_result_id_o, x_result_data_o, x_issue_ready_o} !== {1'b1, 4'd4, 32'd100, 1'b0}) begin
            fails++;
            $display("FAIL full_drain: v=%b id=%0d data=%0d ready=%b required v=1 id=4 data=100 ready=0",
                     x_result_valid_o, x_result_id_o, x_result_data_o, x_issue_ready_o);
        end
        tick();
        #1;
        tests++;
        if (x_issue_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL full_reopen: ready=%b required 1", x_issue_ready_o);
        end
    endtask

    task automatic test_reset_midflight();
        tick();
        idle();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        x_commit_valid_i = 1'b1;
        x_commit_id_i    = 4'd5;
        #1;
        tests++;
        if (x_result_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_valid: valid=%b required 0", x_result_valid_o);
        end
        tick();
        x_commit_valid_i = 1'b0;
        #1;
        tests++;
        if (x_result_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_stale: valid=%b required 0 after commit of flushed id", x_result_valid_o);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            x_issue_valid_i = 1'b1;
            x_issue_instr_i = mk_instr(3'd3, 5'd1);
            x_issue_id_i    = 4'(k);
            #1;
            tests++;
            if (x_issue_ready_o !== (k < 4)) begin
                fails++;
                $display("FAIL rst_mid_issue%0d: ready=%b required %0d", k, x_issue_ready_o, (k < 4));
            end
        end
        do_reset();
    endtask

    task automatic test_hold_reject();
        tick();
        x_result_ready_i = 1'b0;
        x_issue_valid_i  = 1'b1;
        x_issue_instr_i  = mk_instr(3'd2, 5'd9);
        x_issue_id_i     = 4'd9;
        x_issue_rs_i     = {32'h00FF_00FF, 32'h0F0F_0F0F};
        x_commit_valid_i = 1'b1;
        x_commit_id_i    = 4'd9;
        x_commit_kill_i  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            idle();
            if (k == 1) begin
                x_issue_valid_i = 1'b1;
                x_issue_instr_i = 32'h0000_0533;
                x_issue_id_i    = 4'd14;
            end
            #1;
            tests++;
            if ({x_result_valid_o, x_result_id_o, x_result_rd_o, x_result_data_o} !== {1'b1, 4'd9, 5'd9, 32'h0FF0_0FF0}) begin
                fails++;
                $display("FAIL hold_cycle%0d: v=%b id=%0d rd=%0d data=%h required v=1 id=9 rd=9 data=0ff00ff0",
                         k, x_result_valid_o, x_result_id_o, x_result_rd_o, x_result_data_o);
            end
            if (k == 1) begin
                tests++;
                if ({x_issue_accept_o, x_issue_writeback_o, x_issue_ready_o} !== 3'b001) begin
                    fails++;
                    $display("FAIL reject_decode: accept/wb/ready=%b required 001", {x_issue_accept_o, x_issue_writeback_o, x_issue_ready_o});
                end
            end
        end
        // rejected offer must not have consumed a slot: three more fit, the next does not
        for (int k = 0; k < 4; k++) begin
            tick();
            x_issue_valid_i = 1'b1;
            x_issue_instr_i = mk_instr(3'd0, 5'd3);
            x_issue_id_i    = 4'(10 + k);
            #1;
            tests++;
            if (x_issue_ready_o !== (k < 3)) begin
                fails++;
                $display("FAIL reject_occupancy%0d: ready=%b required %0d", k, x_issue_ready_o, (k < 3));
            end
        end
        x_result_ready_i = 1'b1;
        do_reset();
    endtask

    task automatic test_random();
        logic [3:0] nid;
        logic [3:0] cand[$];
        logic [3:0] base;
        logic       exp_ready, exp_acc, exp_rv, will_alloc, do_pop;
        logic [31:0] a, b, r;
        int         roll;
        mdl_t       e;
        do_reset();
        mq.delete();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            tick();
            idle();
            x_issue_rs_valid_i = ($urandom_range(0, 99) < 85) ? 2'b11 : 2'($urandom_range(0, 3));
            x_issue_valid_i    = 1'($urandom_range(0, 1));
            base = 4'($urandom_range(0, 15));
            nid  = base;
            for (int j = 0; j < 16; j++) begin
                if (!id_in_q(4'(base + j))) begin
                    nid = 4'(base + j);
                    break;
                end
            end
            x_issue_id_i    = nid;
            x_issue_instr_i = ($urandom_range(0, 9) < 8) ? mk_instr(3'($urandom_range(0, 3)), 5'($urandom_range(0, 31))) : $urandom();
            x_issue_rs_i    = {$urandom(), $urandom()};
            exp_ready  = (mq.size() < 4) && (x_issue_rs_valid_i == 2'b11);
            exp_acc    = (x_issue_instr_i[6:0] == 7'h0B) && (x_issue_instr_i[31:25] == 7'd0) && (x_issue_instr_i[14:12] <= 3'd3);
            will_alloc = x_issue_valid_i && exp_ready && exp_acc;
            cand.delete();
            foreach (mq[i]) if (mq[i].st == 0) cand.push_back(mq[i].id);
            if (will_alloc) cand.push_back(nid);
            roll = $urandom_range(0, 99);
            if (roll < 40 && cand.size() > 0) begin
                x_commit_valid_i = 1'b1;
                x_commit_id_i    = cand[$urandom_range(0, cand.size() - 1)];
                x_commit_kill_i  = ($urandom_range(0, 3) == 0);
            end else if (roll < 50) begin
                base = 4'($urandom_range(0, 15));
                for (int j = 0; j < 16; j++) begin
                    if (!id_in_q(4'(base + j)) && (4'(base + j) != nid)) begin
                        x_commit_valid_i = 1'b1;
                        x_commit_id_i    = 4'(base + j);
                        x_commit_kill_i  = 1'($urandom_range(0, 1));
                        break;
                    end
                end
            end
            x_result_ready_i = ($urandom_range(0, 3) != 0);
            #1;
            exp_rv = (mq.size() > 0) && (mq[0].st == 1);
            tests++;
            if ({x_issue_ready_o, x_issue_accept_o, x_issue_writeback_o} !== {exp_ready, exp_acc, exp_acc}) begin
                fails++;
                $display("FAIL rnd_issue c%0d: ready/accept/wb=%b required %b", cyc,
                         {x_issue_ready_o, x_issue_accept_o, x_issue_writeback_o}, {exp_ready, exp_acc, exp_acc});
            end
            tests++;
            if ({x_result_valid_o, x_result_we_o} !== {exp_rv, exp_rv}) begin
                fails++;
                $display("FAIL rnd_valid c%0d: valid/we=%b required %b", cyc, {x_result_valid_o, x_result_we_o}, {exp_rv, exp_rv});
            end
            if (exp_rv) begin
                tests++;
                if ({x_result_id_o, x_result_rd_o, x_result_data_o} !== {mq[0].id, mq[0].rd, mq[0].dat}) begin
                    fails++;
                    $display("FAIL rnd_result c%0d: id=%0d rd=%0d data=%h required id=%0d rd=%0d data=%h", cyc,
                             x_result_id_o, x_result_rd_o, x_result_data_o, mq[0].id, mq[0].rd, mq[0].dat);
                end
            end
            do_pop = (mq.size() > 0) && ((mq[0].st == 2) || ((mq[0].st == 1) && x_result_ready_i));
            if (will_alloc) begin
                a = x_issue_rs_i[31:0];
                b = x_issue_rs_i[63:32];
                case (x_issue_instr_i[14:12])
                    3'd0:    r = a + b;
                    3'd1:    r = a - b;
                    3'd2:    r = a ^ b;
                    default: r = a & b;
                endcase
                e.id  = nid;
                e.rd  = x_issue_instr_i[11:7];
                e.dat = r;
                e.st  = 0;
                mq.push_back(e);
            end
            if (x_commit_valid_i) begin
                foreach (mq[i]) if (mq[i].id == x_commit_id_i && mq[i].st == 0) mq[i].st = x_commit_kill_i ? 2 : 1;
            end
            if (do_pop) void'(mq.pop_front());
        end
        do_reset();
    endtask

    initial begin
        rst_ni           = 1'b0;
        x_result_ready_i = 1'b1;
        idle();
        test_reset();
        test_add();
        test_sub_wrap();
        test_kill_order();
        test_full();
        test_reset_midflight();
        test_hold_reject();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/xif_alu_coproc.md
XIF_ALU_COPROC -- requirements
Module: xif_alu_coproc

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-002 SHALL have parameter X_ID_WIDTH, default 4, width of the eXtension-interface instruction id.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port x_issue_valid_i  input  1  core offers an instruction.
REQ-006 SHALL have port x_issue_ready_o  output  1  coprocessor can take the offer.
REQ-007 SHALL have port x_issue_instr_i  input  32  offered instruction word.
REQ-008 SHALL have port x_issue_id_i  input  X_ID_WIDTH  offered instruction id.
REQ-009 SHALL have port x_issue_rs_i  input  64  {rs2, rs1} operands.
REQ-010 SHALL have port x_issue_rs_valid_i  input  2  per-operand valid.
REQ-011 SHALL have port x_issue_accept_o  output  1  instruction is handled here.
REQ-012 SHALL have port x_issue_writeback_o  output  1  accepted instruction writes rd.
REQ-013 SHALL have port x_commit_valid_i  input  1  commit/kill event.
REQ-014 SHALL have port x_commit_id_i  input  X_ID_WIDTH  id being committed or killed.
REQ-015 SHALL have port x_commit_kill_i  input  1  1 = kill, 0 = commit.
REQ-016 SHALL have port x_result_valid_o  output  1  result offered.
REQ-017 SHALL have port x_result_ready_i  input  1  core takes result.
REQ-018 SHALL have port x_result_id_o  output  X_ID_WIDTH  id of offered result.
REQ-019 SHALL have port x_result_rd_o  output  5  destination register.
REQ-020 SHALL have port x_result_data_o  output  32  result value.
REQ-021 SHALL have port x_result_we_o  output  1  register write enable, equal to x_result_valid_o.

Function
REQ-022 Decode SHALL be combinational: accepted iff opcode [6:0]=7'b0001011, funct7 [31:25]=0, funct3 in {000 ADD, 001 SUB, 010 XOR, 011 AND}; x_issue_accept_o = x_issue_writeback_o = that decode.
REQ-023 x_issue_ready_o SHALL equal (queue not full) AND (x_issue_rs_valid_i == 2'b11); no same-cycle pop bypass when full.
REQ-024 Issue handshake = valid AND ready; non-accepted handshakes SHALL not allocate an entry.
REQ-025 Accepted handshake SHALL allocate the tail entry: id, rd [11:7], 32-bit result computed at issue (modulo-2^32 add/sub, bitwise xor/and), committed=0, killed=0.
REQ-026 Commit event SHALL mark the single valid entry with matching id committed (kill=0) or killed (kill=1); no matching entry -> ignored.
REQ-027 Commit whose id equals an issue handshaking in the same cycle SHALL apply to the newly allocated entry.
REQ-028 Head entry committed -> x_result_valid_o=1 with its id/rd/data, held stable until x_result_ready_i=1; then entry pops.
REQ-029 Head entry killed -> popped silently in one cycle, no result offered.
REQ-030 Results SHALL leave in issue order; result valid no earlier than the cycle after the head's commit event.
REQ-031 Pointers SHALL wrap modulo DEPTH; full = DEPTH entries valid; empty -> x_result_valid_o=0.
REQ-032 Issue and pop in the same cycle SHALL both take effect, occupancy unchanged.

Reset
REQ-033 rst_ni=0 at a clock edge SHALL empty the queue, clear all flags and pointers, regardless of in-flight transactions.
REQ-034 During and after reset until new traffic: x_result_valid_o=0, x_result_we_o=0, x_result_id_o=0, x_result_rd_o=0, x_result_data_o=0; x_issue_ready_o follows REQ-023 with empty queue.

Verification
REQ-035 Issue ADD id=3 rd=5 rs1=7 rs2=9, commit id=3 next cycle, ready=1 -> result valid one cycle after commit, id=3, rd=5, data=16.
REQ-036 Issue SUB rs1=0 rs2=1 id=0, commit -> data=32'hFFFF_FFFF (wrap).
REQ-037 Issue ids 0,1,2 then commit 2, kill 1, commit 0 -> results id 0 then id 2 only, in that order.
REQ-038 Issue 4 accepted ops with no commits -> x_issue_ready_o=0 on 5th offer; commit+drain one -> ready=1 next cycle.
REQ-039 Hold x_result_ready_i=0 for 5 cycles on valid result -> id/rd/data unchanged; issue of opcode 7'b0110011 -> accept=0, queue unchanged.
REQ-040 Assert rst_ni=0 with 3 entries queued -> next cycle result valid=0, queue empty, 4 new issues accepted.
